poets_mem_arbiter: RTL
======================

Name: poets_mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 32-bit on-chip system memory (12800 words, 14-bit word address, byte enables, 1-cycle read latency).
- Requester 0 is the processor data port; requester 1 is the host/DMA port.
- Sits between the two Avalon-MM-style masters and the memory's slave port.
- Provides round-robin arbitration, waitrequest back-pressure, read-data routing with readdatavalid, and clock-enable gating during reset requests.

Parameters:
- ADDR_W, 14, word-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DEPTH, 12800, number of implemented memory words.
- FAIR_BURST, 1, consecutive grants a requester may hold while the other waits (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  memory reset-request; blocks new grants and drops mem_clken.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  DATA_W/8  requester 0 byte enables.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_waitrequest  out  1  requester 0 stall.
- m0_readdata  out  DATA_W  requester 0 read data.
- m0_readdatavalid  out  1  requester 0 read data valid.
- m1_*  same set as m0_* for requester 1.
- mem_address  out  ADDR_W  to memory.
- mem_byteenable  out  DATA_W/8  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_clken  out  1  memory clock enable.
- mem_readdata  in  DATA_W  unregistered memory output, valid 1 cycle after the address cycle.

Behaviour:
- Request: mN_req = mN_read | mN_write. Read and write asserted together is illegal; write wins and the read is dropped.
- Grant (combinational):
  - Only one requester active: that requester is granted.
  - Both active: the one indicated by priority register `prio` is granted.
  - reset_req=1: no grant.
- mN_waitrequest = mN_req & ~grantN. A requester must hold its signals stable while stalled.
- Memory drive:
  - Granted cycle: mem_* carry the granted requester's signals, mem_chipselect=1, mem_write equals its write.
  - Ungrant cycle: mem_chipselect=0, mem_write=0, address/data hold the last value.
  - mem_clken = ~reset_req.
- Read latency: grant of a read in cycle N gives mN_readdatavalid=1 in cycle N+1, with mN_readdata = mem_readdata. Reads may be granted back to back (one per cycle, full throughput).
- mN_readdata is driven with mem_readdata at all times; only valid when readdatavalid=1.
- Tracking registers: rd_pend (1 bit) and rd_who (1 bit), set on a granted read, cleared otherwise.
- Fairness counter `run` (4 bit):
  - Counts consecutive grants to the same requester while the other is requesting.
  - When run reaches FAIR_BURST, `prio` flips to the other requester and run resets to 0.
  - A grant while the other is idle resets run to 0 and sets prio to the non-granted requester.
- States: IDLE (no req); GRANT0 or GRANT1 (from grant mux); HOLD (reset_req=1: no grants, pending readdatavalid still delivered next cycle).
- Reset (async): prio=0, run=0, rd_pend=0, rd_who=0. Outputs: mN_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0. mN_waitrequest follows its request combinationally with no grant while reset=1.
- Reset mid-read: the pending readdatavalid is discarded and never asserted after reset.
- Simultaneous first requests after reset: m0 is granted first.

Optional Feature:
- Macro POETS_MEM_ARB_RANGE_CHECK_EN.
- Defined:
  - A granted access with address >= DEPTH is not forwarded (mem_chipselect=0).
  - A read returns 32'hDEAD_BEEF with readdatavalid in the normal N+1 slot.
  - A write is dropped.
  - Extra output range_err (1 bit, sticky) is set and is cleared only by reset.
- Undefined: addresses pass through unchecked and no range_err port exists.

Test Plan:
- Reset, then m0 read addr 0x0010 with memory word 0x12345678 -> m0_waitrequest=0, m0_readdatavalid=1 exactly one cycle later, m0_readdata=0x12345678, m1_readdatavalid=0.
- m0 and m1 both write continuously (m0 addr 0x0001, m1 addr 0x0002), FAIR_BURST=1 -> grants alternate m0,m1,m0,m1; each waitrequest high every other cycle.
- Same stimulus with FAIR_BURST=3 -> grant pattern m0×3, m1×3, repeating.
- m1 reads 4 back-to-back addresses 0x0100..0x0103 -> 4 consecutive m1_readdatavalid cycles with the matching data, no bubbles.
- reset_req pulsed 3 cycles during m0 read stream -> the in-flight read still returns next cycle; no grants and mem_clken=0 for 3 cycles; stream resumes afterwards.
- With POETS_MEM_ARB_RANGE_CHECK_EN, m0 read addr 12800 -> mem_chipselect=0, m0_readdata=0xDEADBEEF next cycle, range_err=1 and held; m0 write addr 13000 -> memory unchanged.

Source files
------------

// File: rtl/poets_mem_arbiter.sv
// poets_mem_arbiter
//   Two-master round-robin arbiter in front of the single-port on-chip system
//   memory (1-cycle read latency). Master 0 is the processor data port,
//   master 1 the host/DMA port.
//
//   Ports
//     clk, reset        : clock, asynchronous active-high reset
//     reset_req         : memory reset request; blocks grants, drops mem_clken
//     m0_* / m1_*       : Avalon-MM style masters (address, byteenable, read,
//                         write, writedata, waitrequest, readdata,
//                         readdatavalid)
//     mem_*             : memory slave port (address, byteenable, chipselect,
//                         write, writedata, clken, readdata)
//     range_err         : sticky out-of-range flag (only with the option below)
//
//   Build option
//     POETS_MEM_ARB_RANGE_CHECK_EN : accesses with address >= DEPTH are not
//       forwarded; reads return 32'hDEAD_BEEF, writes are dropped, and
//       range_err latches until reset.
module poets_mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 12800,
  parameter int FAIR_BURST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
  output logic                  range_err,
`endif
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W/8;

  if (FAIR_BURST < 1 || FAIR_BURST > 15) begin : g_bad_burst
    $error("FAIR_BURST out of range 1..15");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH does not fit in ADDR_W");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1, ST_HOLD} arb_st_t;

  arb_st_t              st;
  logic                 prio, prio_d;
  logic [3:0]           run, run_d;
  logic                 rd_pend, rd_pend_d, rd_who, rd_who_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [BE_W-1:0]      be_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 req0, req1, gnt, who, other_req, oob, fwd;
  logic [ADDR_W-1:0]    sel_addr;
  logic [BE_W-1:0]      sel_be;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_write;
  logic [4:0]           run_inc;
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
  logic                 rd_oob, rd_oob_d, err_q;
`endif

  // A simultaneous read+write counts as a write; the read half is ignored.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Arbitration state is a pure function of this cycle's requests and prio.
  always_comb begin
    st = ST_IDLE;
    if (reset || reset_req)         st = ST_HOLD;
    else if (req0 && (!req1 || !prio)) st = ST_GRANT0;
    else if (req1)                  st = ST_GRANT1;
  end

  // Output process: grant mux and memory drive.
  always_comb begin
    gnt       = (st == ST_GRANT0) || (st == ST_GRANT1);
    who       = (st == ST_GRANT1);
    other_req = who ? req0 : req1;
    sel_addr  = who ? m1_address    : m0_address;
    sel_be    = who ? m1_byteenable : m0_byteenable;
    sel_wdata = who ? m1_writedata  : m0_writedata;
    sel_write = who ? m1_write      : m0_write;
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
    oob = gnt && ({1'b0, sel_addr} >= (ADDR_W+1)'(DEPTH));
`else
    oob = 1'b0;
`endif
    fwd            = gnt && !oob;
    mem_chipselect = fwd;
    mem_write      = fwd && sel_write;
    // Idle cycles keep the last address/data on the bus.
    mem_address    = fwd ? sel_addr  : addr_q;
    mem_byteenable = fwd ? sel_be    : be_q;
    mem_writedata  = fwd ? sel_wdata : wdata_q;
    mem_clken      = !reset_req;
    m0_waitrequest = req0 && (st != ST_GRANT0);
    m1_waitrequest = req1 && (st != ST_GRANT1);
    m0_readdatavalid = rd_pend && !rd_who;
    m1_readdatavalid = rd_pend &&  rd_who;
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
    m0_readdata = rd_oob ? DATA_W'(32'hDEAD_BEEF) : mem_readdata;
`else
    m0_readdata = mem_readdata;
`endif
    m1_readdata = m0_readdata;
  end

  // Next-state process: fairness counter and read tracking.
  always_comb begin
    prio_d    = prio;
    run_d     = run;
    run_inc   = {1'b0, run} + 5'd1;
    rd_pend_d = gnt && !sel_write;
    rd_who_d  = gnt && !sel_write && who;
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
    rd_oob_d  = gnt && !sel_write && oob;
`endif
    if (gnt) begin
      if (!other_req) begin
        // Uncontended grant: next contention goes to the other side.
        run_d  = 4'd0;
        prio_d = !who;
      end else if (run_inc >= 5'(FAIR_BURST)) begin
        run_d  = 4'd0;
        prio_d = !who;
      end else begin
        run_d  = run_inc[3:0];
        prio_d = who;
      end
    end
  end

  // State register process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio    <= 1'b0;
      run     <= 4'd0;
      rd_pend <= 1'b0;
      rd_who  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
      rd_oob  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      prio    <= prio_d;
      run     <= run_d;
      rd_pend <= rd_pend_d;
      rd_who  <= rd_who_d;
      if (fwd) begin
        addr_q  <= sel_addr;
        be_q    <= sel_be;
        wdata_q <= sel_wdata;
      end
`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
      rd_oob  <= rd_oob_d;
      err_q   <= err_q | oob;
`endif
    end
  end

`ifdef POETS_MEM_ARB_RANGE_CHECK_EN
  assign range_err = err_q;
`endif

endmodule
